// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide sequencer.
//   MULDIV_FUNCT7  : R-type funct7 that selects the M extension
//   F3_*           : funct3 encodings of the eight M-extension ops
//   md_state_e     : sequencer state encoding (S_IDLE, S_BUSY, S_DONE)
//   helpers        : operand signedness per funct3, magnitude of a 32-bit value
package muldiv_pkg;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic f3_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM
  function automatic logic f3_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: iterative datapath for the multiply/divide sequencer.
// Holds the 64-bit accumulator {hi, lo}: product for multiply, {remainder,
// quotient} for divide. Operands are reduced to magnitudes on load and the
// sign is restored when the result register is written on finish.
//   clk, reset       : clock, synchronous active-high reset
//   load             : capture funct3, operand magnitudes and sign flags
//   step             : perform one shift-add / restoring-subtract iteration
//   finish           : write result (bypass_value if bypass_en, else the
//                      sign-corrected accumulator after this cycle's step)
//   funct3, op_a/b   : raw operation and operands (used on load)
//   result           : registered result, zero outside the finish cycle
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        finish,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        bypass_en,
  input  logic [31:0] bypass_value,
  output logic [31:0] result
);

  logic [2:0]  f3_q;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        neg_res;
  logic        neg_rem;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_trial;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [63:0] acc_next;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] corrected;

  always_comb begin
    a_neg = f3_a_signed(funct3) & op_a[31];
    b_neg = f3_b_signed(funct3) & op_b[31];
    mag_a = mag32(op_a, a_neg);
    mag_b = mag32(op_b, b_neg);

    // multiply: lo holds the multiplier, add multiplicand into hi, shift right
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'h0)};
    mul_next = {mul_sum, acc[31:1]};

    // restoring divide: shifted remainder may need 33 bits before the compare
    div_trial = {acc[63:32], acc[31]};
    div_sub   = div_trial[31:0] - opnd;
    if (div_trial >= {1'b0, opnd}) begin
      div_next = {div_sub, acc[30:0], 1'b1};
    end else begin
      div_next = {acc[62:0], 1'b0};
    end

    acc_next = step ? (f3_q[2] ? div_next : mul_next) : acc;

    prod = neg_res ? -acc_next : acc_next;
    quo  = neg_res ? -acc_next[31:0] : acc_next[31:0];
    rem  = neg_rem ? -acc_next[63:32] : acc_next[63:32];

    if (f3_q[2]) begin
      corrected = f3_q[1] ? rem : quo;
    end else begin
      corrected = (f3_q == F3_MUL) ? prod[31:0] : prod[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f3_q    <= 3'b000;
      acc     <= 64'h0;
      opnd    <= 32'h0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= 32'h0;
    end else begin
      if (load) begin
        f3_q    <= funct3;
        acc     <= {32'h0, (funct3[2] ? mag_a : mag_b)};
        opnd    <= funct3[2] ? mag_b : mag_a;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
      end else begin
        acc <= acc_next;
      end
      result <= finish ? (bypass_en ? bypass_value : corrected) : 32'h0;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: EX-stage sequencer for RV32M multiply/divide.
// Captures the forwarded operands, stalls IF/ID/EX while the iterative core
// runs, then strobes the result for one cycle so the instruction retires.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle 64-bit
// combinational multiplier and finish one cycle after the request.
//   clk, reset          : clock, synchronous active-high reset
//   md_req              : M-extension instruction present in EX
//   md_funct3           : operation select
//   md_op_a, md_op_b    : forwarded rs1 / rs2 values
//   flush               : kill the instruction in EX
//   md_stall            : combinational pipeline freeze
//   md_busy             : registered, high while iterating
//   md_done, md_result  : registered one-cycle result strobe and value
//
// state  | meaning
// S_IDLE | waiting for a request; starts on md_req & !flush
// S_BUSY | one iteration per cycle, cnt 0..ITER-1
// S_DONE | md_done/md_result valid for the retiring instruction
module ex_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            md_req,
  input  logic [2:0]      md_funct3,
  input  logic [XLEN-1:0] md_op_a,
  input  logic [XLEN-1:0] md_op_b,
  input  logic            flush,
  output logic            md_stall,
  output logic            md_busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  md_state_e   state;
  logic [5:0]  cnt;

  logic        start;
  logic        last_iter;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] sc_value;
  logic        bypass_en;
  logic [31:0] bypass_value;
  logic        load;
  logic        step;
  logic        finish;

`ifdef MULDIV_FAST_MUL_EN
  logic        fa_neg;
  logic        fb_neg;
  logic [63:0] fprod_mag;
  logic [63:0] fprod;
  logic [31:0] fast_value;

  always_comb begin
    fa_neg     = f3_a_signed(md_funct3) & md_op_a[31];
    fb_neg     = f3_b_signed(md_funct3) & md_op_b[31];
    fprod_mag  = {32'h0, mag32(md_op_a, fa_neg)} * {32'h0, mag32(md_op_b, fb_neg)};
    fprod      = (fa_neg ^ fb_neg) ? -fprod_mag : fprod_mag;
    fast_value = (md_funct3 == F3_MUL) ? fprod[31:0] : fprod[63:32];
  end
`endif

  always_comb begin
    start     = (state == S_IDLE) && md_req && !flush;
    last_iter = (cnt == 6'(ITER - 1));

    // divide by zero and signed overflow resolve without iterating
    div_zero = md_funct3[2] && (md_op_b == 32'h0);
    div_ovf  = md_funct3[2] && !md_funct3[0] &&
               (md_op_a == 32'h8000_0000) && (md_op_b == 32'hFFFF_FFFF);
    if (div_zero) begin
      sc_value = md_funct3[1] ? md_op_a : 32'hFFFF_FFFF;
    end else begin
      sc_value = md_funct3[1] ? 32'h0 : 32'h8000_0000;
    end

`ifdef MULDIV_FAST_MUL_EN
    bypass_en    = div_zero || div_ovf || !md_funct3[2];
    bypass_value = md_funct3[2] ? sc_value : fast_value;
`else
    bypass_en    = div_zero || div_ovf;
    bypass_value = sc_value;
`endif

    load     = start;
    step     = (state == S_BUSY) && !flush;
    finish   = (start && bypass_en) || (step && last_iter);
    md_stall = start || (state == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 6'd0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          md_done <= 1'b0;
          if (start) begin
            cnt <= 6'd0;
            if (bypass_en) begin
              state   <= S_DONE;
              md_busy <= 1'b0;
              md_done <= 1'b1;
            end else begin
              state   <= S_BUSY;
              md_busy <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            state   <= S_IDLE;
            md_busy <= 1'b0;
          end else if (last_iter) begin
            state   <= S_DONE;
            md_busy <= 1'b0;
            md_done <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_DONE: begin
          // md_req here is still the retiring instruction; flush is too late
          state   <= S_IDLE;
          md_done <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          md_busy <= 1'b0;
          md_done <= 1'b0;
        end
      endcase
    end
  end

  muldiv_iter_core u_core (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .step         (step),
    .finish       (finish),
    .funct3       (md_funct3),
    .op_a         (md_op_a),
    .op_b         (md_op_b),
    .bypass_en    (bypass_en),
    .bypass_value (bypass_value),
    .result       (md_result)
  );

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk;
  logic        reset;
  logic        md_req;
  logic [2:0]  md_funct3;
  logic [31:0] md_op_a;
  logic [31:0] md_op_b;
  logic        flush;
  logic        md_stall;
  logic        md_busy;
  logic        md_done;
  logic [31:0] md_result;

  int n_cmp = 0;
  int n_bad = 0;

  ex_muldiv_ctrl #(.XLEN(32), .ITER(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_req    (md_req),
    .md_funct3 (md_funct3),
    .md_op_a   (md_op_a),
    .md_op_b   (md_op_b),
    .flush     (flush),
    .md_stall  (md_stall),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .md_result (md_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called in the request cycle T with md_req and operands already driven.
  task automatic wait_done(input logic [31:0] exp_res, input int exp_lat, input string nm);
    int cyc;
    logic window_ok;
    check({nm, " stall_at_T"}, {31'h0, md_stall}, 32'h1);
    window_ok = 1'b1;
    cyc = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      md_op_a   = $urandom;
      md_op_b   = $urandom;
      md_funct3 = 3'($urandom_range(0, 7));
      if (md_done === 1'b1 || cyc >= 100) break;
      if (md_stall !== 1'b1 || md_busy !== 1'b1) window_ok = 1'b0;
    end
    check({nm, " latency"}, 32'(cyc), 32'(exp_lat));
    check({nm, " result"}, md_result, exp_res);
    check({nm, " stall_in_done"}, {31'h0, md_stall}, 32'h0);
    check({nm, " busy_stall_window"}, {31'h0, window_ok}, 32'h1);
    md_req = 1'b0;
    @(posedge clk);
    #1;
    check({nm, " done_one_cycle"}, {31'h0, md_done}, 32'h0);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string nm);
    md_funct3 = f3;
    md_op_a   = a;
    md_op_b   = b;
    md_req    = 1'b1;
    #1;
    wait_done(exp_res, exp_lat, nm);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        early_done;

    vecs[0]  = '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
    vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT};
    vecs[4]  = '{F3_MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001, MUL_LAT};
    vecs[5]  = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[6]  = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[7]  = '{F3_DIVU,   32'd100,       32'd7,         32'd14,        33};
    vecs[8]  = '{F3_REMU,   32'd100,       32'd7,         32'd2,         33};
    vecs[9]  = '{F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[10] = '{F3_REM,    32'd5,         32'd0,         32'd5,         1};
    vecs[11] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[12] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[13] = '{F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[14] = '{F3_REMU,   32'd5,         32'd0,         32'd5,         1};
    vecs[15] = '{F3_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};

    reset = 1'b1; md_req = 1'b0; flush = 1'b0;
    md_funct3 = 3'b000; md_op_a = 32'h0; md_op_b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'h0, md_busy}, 32'h0);
    check("reset done", {31'h0, md_done}, 32'h0);
    check("reset result", md_result, 32'h0);
    check("reset stall", {31'h0, md_stall}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // directed vectors, issued back to back
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // flush in BUSY at T+10, flush blocking a request in IDLE, restart at T+12
    md_funct3 = F3_DIV; md_op_a = 32'd1000; md_op_b = 32'd3; md_req = 1'b1;
    early_done = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (md_done !== 1'b0) early_done = 1'b1;
    end
    flush = 1'b1;
    #1;
    check("flush stall_at_T10", {31'h0, md_stall}, 32'h1);
    @(posedge clk);
    #1;
    check("flush stall_at_T11", {31'h0, md_stall}, 32'h0);
    check("flush busy_at_T11", {31'h0, md_busy}, 32'h0);
    check("flush done_at_T11", {31'h0, md_done}, 32'h0);
    @(posedge clk);
    #1;
    check("flush no_start_T12", {31'h0, md_busy | md_done}, 32'h0);
    check("flush no_early_done", {31'h0, early_done}, 32'h0);
    flush = 1'b0;
    run_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 33, "after_flush");

    // synchronous reset mid-operation with md_req held through it
`ifdef MULDIV_FAST_MUL_EN
    md_funct3 = F3_DIVU; md_op_a = 32'd100; md_op_b = 32'd7;
`else
    md_funct3 = F3_MUL; md_op_a = 32'h0000_0007; md_op_b = 32'hFFFF_FFFD;
`endif
    md_req = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset busy", {31'h0, md_busy}, 32'h0);
    check("midreset done", {31'h0, md_done}, 32'h0);
    check("midreset result", md_result, 32'h0);
    reset = 1'b0;
    a = md_op_a;
    b = md_op_b;
    wait_done(ref_md(md_funct3, a, b), 33, "after_reset");

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = rand_op();
      b  = rand_op();
      run_op(f3, a, b, ref_md(f3, a, b), ref_lat(f3, a, b), $sformatf("rnd%0d_f%0d", i, f3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
